// File: rtl/alu16_pkg.sv
// Shared types and constants for the 16-bit ALU execute stage.
package alu16_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_TAG_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
    op_e                  sel;
    logic [ALU_TAG_W-1:0] tag;
  } bundle_t;

endpackage

// File: rtl/alu16_exec_stage_if.sv
// Decode-side and writeback-side handshake bundle of the execute stage.
interface alu16_exec_stage_if
  import alu16_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAG_W = ALU_TAG_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;
  logic [15:0]      op_count;

  modport master (
    output in_valid, in_a, in_b, in_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_flags, op_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_flags, op_count
  );
endinterface

// File: rtl/alu16_flags.sv
// Combinational add/sub/and/or with {V,C,N,Z} status flags.
module alu16_flags
  import alu16_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              sel_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o
);
  logic             is_sub_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_s;
  logic             carry_s;
  logic             ovf_s;

  // One shared adder; subtraction is a + ~b + 1 so carry-out means no borrow.
  always_comb begin
    is_sub_s = (sel_i == OP_SUB);
    b_eff_s  = is_sub_s ? ~b_i : b_i;
    sum_s    = {1'b0, a_i} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, is_sub_s};
    result_o = {WIDTH{1'b0}};
    carry_s  = 1'b0;
    ovf_s    = 1'b0;
    case (sel_i)
      OP_ADD: begin
        result_o = sum_s[WIDTH-1:0];
        carry_s  = sum_s[WIDTH];
        ovf_s    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_s[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        result_o = sum_s[WIDTH-1:0];
        carry_s  = sum_s[WIDTH];
        ovf_s    = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sum_s[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND: begin
        result_o = a_i & b_i;
      end
      OP_OR: begin
        result_o = a_i | b_i;
      end
      default: begin
        result_o = {WIDTH{1'b0}};
      end
    endcase
    flags_o         = 4'b0000;
    flags_o[FLAG_Z] = (result_o == {WIDTH{1'b0}});
    flags_o[FLAG_N] = result_o[WIDTH-1];
    flags_o[FLAG_C] = carry_s;
    flags_o[FLAG_V] = ovf_s;
  end

endmodule

// File: rtl/alu16_exec_stage.sv
// Registered ALU execute stage: 2-entry skid buffer, output register,
// bypass when idle, and a count of results accepted downstream.
module alu16_exec_stage
  import alu16_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAG_W = ALU_TAG_W
) (
  input logic               clk,
  input logic               rst,
  alu16_exec_stage_if.slave bus
);
  // Occupancy: buffer count x output register full/empty.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_OUT   = 2'd1;
  localparam logic [1:0] ST_ONE   = 2'd2;
  localparam logic [1:0] ST_FULL  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  bundle_t          buf0_q, buf0_d;
  bundle_t          buf1_q, buf1_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [3:0]       flags_q, flags_d;
  logic [15:0]      op_count_q, op_count_d;

  bundle_t          in_bundle_s;
  bundle_t          head_s;
  logic             buf_has_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             load_out_s;
  logic [WIDTH-1:0] alu_result_s;
  logic [3:0]       alu_flags_s;

  // Handshake qualifiers and head selection (buffer head, else the live input).
  always_comb begin
    in_bundle_s.a   = bus.in_a;
    in_bundle_s.b   = bus.in_b;
    in_bundle_s.sel = op_e'(bus.in_sel);
    in_bundle_s.tag = bus.in_tag;
    in_fire_s       = bus.in_valid && in_ready_q;
    out_fire_s      = out_valid_q && bus.out_ready;
    buf_has_s       = (state_q == ST_ONE) || (state_q == ST_FULL);
    head_s          = buf_has_s ? buf0_q : in_bundle_s;
  end

  alu16_flags #(.WIDTH(WIDTH)) u_alu (
    .a_i      (head_s.a),
    .b_i      (head_s.b),
    .sel_i    (head_s.sel),
    .result_o (alu_result_s),
    .flags_o  (alu_flags_s)
  );

  // Occupancy transitions, buffer shifting and output-register load select.
  always_comb begin
    state_d    = state_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    load_out_s = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire_s) begin
          state_d    = ST_OUT;
          load_out_s = 1'b1;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_OUT: begin
        if (in_fire_s && out_fire_s) begin
          state_d    = ST_OUT;
          load_out_s = 1'b1;
        end else if (in_fire_s) begin
          state_d = ST_ONE;
          buf0_d  = in_bundle_s;
        end else if (out_fire_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_ONE: begin
        if (in_fire_s && out_fire_s) begin
          state_d    = ST_ONE;
          load_out_s = 1'b1;
          buf0_d     = in_bundle_s;
        end else if (in_fire_s) begin
          state_d = ST_FULL;
          buf1_d  = in_bundle_s;
        end else if (out_fire_s) begin
          state_d    = ST_OUT;
          load_out_s = 1'b1;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a drain can move the state.
        if (out_fire_s) begin
          state_d    = ST_ONE;
          load_out_s = 1'b1;
          buf0_d     = buf1_q;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // Output register and completed-operation counter next state.
  always_comb begin
    if (load_out_s) begin
      result_d = alu_result_s;
      tag_d    = head_s.tag;
      flags_d  = alu_flags_s;
    end else begin
      result_d = result_q;
      tag_d    = tag_q;
      flags_d  = flags_q;
    end
    if (out_fire_s) begin
      op_count_d = op_count_q + 16'd1;
    end else begin
      op_count_d = op_count_q;
    end
  end

  // State registers; reset discards every in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      buf0_q      <= '{a: {WIDTH{1'b0}}, b: {WIDTH{1'b0}}, sel: OP_ADD, tag: {TAG_W{1'b0}}};
      buf1_q      <= '{a: {WIDTH{1'b0}}, b: {WIDTH{1'b0}}, sel: OP_ADD, tag: {TAG_W{1'b0}}};
      result_q    <= {WIDTH{1'b0}};
      tag_q       <= {TAG_W{1'b0}};
      flags_q     <= 4'b0000;
      op_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      result_q    <= result_d;
      tag_q       <= tag_d;
      flags_q     <= flags_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.out_tag    = tag_q;
  assign bus.out_flags  = flags_q;
  assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_alu16_exec_stage.sv
// Scoreboard bench for alu16_exec_stage: random and directed ops against a
// plain-arithmetic reference model, backpressure, reset and counter wrap.
module tb_alu16_exec_stage;
  import alu16_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  tag;
    logic [3:0]  flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu16_exec_stage_if #(.WIDTH(16), .TAG_W(4)) bus ();
  alu16_exec_stage #(.WIDTH(16), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] exp_cnt = 16'h0000;
  int          checks  = 0;
  int          passed  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: integer arithmetic, carry/overflow from value ranges.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [1:0] sel, input logic [3:0] tag);
    exp_t e;
    int ua, ub, sa, sbv, full, sfull;
    bit c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sbv = int'($signed(b));
    c = 1'b0; v = 1'b0; full = 0;
    case (sel)
      2'b00: begin full = ua + ub; c = (full > 65535); sfull = sa + sbv; v = (sfull > 32767) || (sfull < -32768); end
      2'b01: begin full = ua - ub; c = (ua >= ub);     sfull = sa - sbv; v = (sfull > 32767) || (sfull < -32768); end
      2'b10: full = ua & ub;
      default: full = ua | ub;
    endcase
    e.res   = full[15:0];
    e.tag   = tag;
    e.flags = {v, c, e.res[15], (e.res == 16'h0000)};
    return e;
  endfunction

  // Present one bundle, wait (bounded) for acceptance, queue its expectation.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] sel,
                      input logic [3:0] tag, input bit directed, input logic [15:0] dres,
                      input logic [3:0] dflags, output int waits);
    exp_t e;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_sel = sel; bus.in_tag = tag;
    e = model(a, b, sel, tag);
    if (directed) begin e.res = dres; e.flags = dflags; end
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits < 1000) begin waits++; @(negedge clk); end
    check("in_accept", {31'd0, bus.in_ready}, 32'd1);
    if (bus.in_ready) sb.push_back(e);
    else bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    check("drain_empty", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: every out handshake pops and compares one expectation.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_cnt = 16'h0000;
    end else if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("out_result", {16'd0, bus.out_result}, {16'd0, mon_e.res});
        check("out_tag", {28'd0, bus.out_tag}, {28'd0, mon_e.tag});
        check("out_flags", {28'd0, bus.out_flags}, {28'd0, mon_e.flags});
        check("op_count_track", {16'd0, bus.op_count}, {16'd0, exp_cnt});
        exp_cnt = exp_cnt + 16'd1;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, wsum, acc;
    logic [15:0] bp_a[4];
    logic [15:0] bp_b[4];
    logic [15:0] ra, rb;
    logic [1:0]  rs;

    bus.in_valid = 1'b0; bus.in_a = 16'h0; bus.in_b = 16'h0;
    bus.in_sel = 2'b00; bus.in_tag = 4'h0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_result", {16'd0, bus.out_result}, 32'd0);
    check("rst_out_tag", {28'd0, bus.out_tag}, 32'd0);
    check("rst_out_flags", {28'd0, bus.out_flags}, 32'd0);
    check("rst_op_count", {16'd0, bus.op_count}, 32'd0);
    @(posedge clk); #1;
    check("in_ready_after_release", {31'd0, bus.in_ready}, 32'd1);

    // Single ADD with signed overflow, one-cycle latency.
    bus.out_ready = 1'b1;
    send(16'h7FFF, 16'h0001, OP_ADD, 4'd3, 1'b1, 16'h8000, 4'b1010, w);
    bus.in_valid = 1'b0;
    check("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk); #1;
    check("op_count_single", {16'd0, bus.op_count}, 32'd1);

    // Subtraction boundaries.
    send(16'h0005, 16'h0005, OP_SUB, 4'd5, 1'b1, 16'h0000, 4'b0101, w);
    send(16'h0000, 16'h0001, OP_SUB, 4'd6, 1'b1, 16'hFFFF, 4'b0010, w);
    bus.in_valid = 1'b0;
    drain();

    // Backpressure: four ADDs offered while writeback stalls.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin bp_a[i] = 16'($urandom); bp_b[i] = 16'($urandom); end
    acc = 0;
    bus.in_valid = 1'b1; bus.in_a = bp_a[0]; bus.in_b = bp_b[0]; bus.in_sel = OP_ADD; bus.in_tag = 4'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(model(bp_a[acc], bp_b[acc], OP_ADD, acc[3:0]));
        acc++;
      end
      @(posedge clk); #1;
      if (acc < 4) begin bus.in_a = bp_a[acc]; bus.in_b = bp_b[acc]; bus.in_tag = acc[3:0]; end
    end
    check("bp_accepted", acc, 32'd3);
    check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(model(bp_a[acc], bp_b[acc], OP_ADD, acc[3:0]));
        acc++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("bp_fourth_accepted", acc, 32'd4);
    drain();

    // Streaming: 100 random ops back to back, no input stalls expected.
    wsum = 0;
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 2'($urandom_range(3, 0));
      if (i % 10 == 0) rb = ra;
      send(ra, rb, rs, 4'(i), 1'b0, 16'h0, 4'h0, w);
      wsum += w;
    end
    bus.in_valid = 1'b0;
    check("stream_no_stall", wsum, 32'd0);
    drain();

    // Asynchronous reset with the stage full.
    bus.out_ready = 1'b0;
    send(16'h1111, 16'h2222, OP_ADD, 4'd1, 1'b0, 16'h0, 4'h0, w);
    send(16'h3333, 16'h4444, OP_OR,  4'd2, 1'b0, 16'h0, 4'h0, w);
    send(16'h5555, 16'h6666, OP_AND, 4'd3, 1'b0, 16'h0, 4'h0, w);
    bus.in_valid = 1'b0;
    check("full_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_op_count", {16'd0, bus.op_count}, 32'd0);
    check("arst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("arst_out_result", {16'd0, bus.out_result}, 32'd0);
    check("arst_out_flags", {28'd0, bus.out_flags}, 32'd0);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("arst_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      check("arst_no_stale", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk); #1;
    end

    // Counter wrap: 65535 results, then one more.
    for (int i = 0; i < 65535; i++) send(16'h0001, 16'h0001, OP_ADD, 4'd9, 1'b0, 16'h0, 4'h0, w);
    bus.in_valid = 1'b0;
    drain();
    check("count_ffff", {16'd0, bus.op_count}, 32'h0000FFFF);
    send(16'h00F0, 16'h0F0F, OP_OR, 4'd10, 1'b0, 16'h0, 4'h0, w);
    bus.in_valid = 1'b0;
    drain();
    check("count_wrap", {16'd0, bus.op_count}, 32'h00000000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu16_exec_stage.md
# alu16_exec_stage

Registered execute stage wrapped around the team's 16-bit combinational ALU. It accepts operand/opcode bundles from the decode stage over a valid/ready handshake and buffers them in a 2-entry skid buffer. It evaluates add/sub/and/or with status flags and holds the result in an output register until the writeback stage accepts it. Provides full throughput (one op per cycle), registered backpressure, and a completed-operation counter.

## Interface
- WIDTH, 16, operand/result width
- TAG_W, 4, destination-register tag width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decode presents a bundle
- in_ready  out  1  stage can accept; registered
- in_a, in_b  in  WIDTH  operands
- in_sel  in  2  opcode; bit0 = sel0, bit1 = sel1
  - 00 ADD
  - 01 SUB (a-b)
  - 10 AND
  - 11 OR
- in_tag  in  TAG_W  destination tag, passed through unchanged
- out_valid  out  1  result register holds a valid op
- out_ready  in  1  writeback accepts
- out_result  out  WIDTH  ALU result
- out_tag  out  TAG_W  tag of the result
- out_flags  out  4  {V,C,N,Z}
- op_count  out  16  number of results accepted downstream; wraps

## Operation
- Handshake: transfer occurs on a clock edge where valid&&ready. in_valid/in_a/in_b/in_sel/in_tag must stay stable while in_valid && !in_ready. out_* stay stable while out_valid && !out_ready.
- Skid buffer: 2 entries, FIFO order, holding pending bundles. in_ready = (entries < 2), registered from the next-state count.
- Execute: the head entry is computed combinationally. It loads into the output register when the output register is empty or being drained this cycle (out_ready && out_valid).
- Bypass: when the buffer is empty and the output register is free, an accepted input loads directly into the output register on its accept edge.
- Arithmetic: computed at WIDTH+1 bits.
  - ADD: C = carry-out.
  - SUB: computed as a + ~b + 1; C = 1 means no borrow (a >= b unsigned).
  - AND/OR: C = 0, V = 0.
  - V (signed overflow), ADD: a[15]==b[15] && r[15]!=a[15].
  - V, SUB: a[15]!=b[15] && r[15]!=a[15].
  - N = r[WIDTH-1]; Z = (r == 0).
- op_count increments by 1 on each out handshake; 0xFFFF wraps to 0x0000.
- Occupancy state machine (buffer count 0/1/2 × output reg full/empty):
  - EMPTY (0, empty)
  - OUT (0, full)
  - ONE (1, full)
  - FULL (2, full)
  - A buffered entry with an empty output register never persists past one edge.
- Simultaneous in-accept and out-accept in OUT/ONE: occupancy is unchanged; data advances one slot.
- FULL with out_ready=1: output loads the head, in_ready rises on the next cycle.
- Reset (asynchronous, mid-operation included): all in-flight ops are discarded.
  - in_ready = 0 while rst is asserted, 1 on the first edge after release.
  - out_valid = 0, out_result = 0, out_tag = 0, out_flags = 0, op_count = 0, buffer count = 0.

## Timing
- Latency: input accepted at edge N (stage empty) → out_valid=1 after edge N, visible in cycle N+1.
- Throughput: 1 op/cycle with out_ready held high.
- Backpressure: after out_ready drops, up to 2 further inputs are accepted (the buffer fills). in_ready is low in the cycle after the second fills.
- No combinational path from out_ready to in_ready. in_* reach out_* only through registers.
- Critical path: skid head mux → WIDTH+1 adder → flag logic → output register.

## Structure
- Shared package alu16_pkg:
  - opcode enum OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11
  - flag bit index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3
  - bundle struct {a, b, sel, tag}
- Sub-module alu16_flags: combinational result + {V,C,N,Z} from a, b, sel. The stage instantiates it once on the head bundle.
- Skid buffer and output register are inline in alu16_exec_stage.

## Test plan
- Single op: ADD a=0x7FFF, b=0x0001, tag=3, out_ready=1 → next cycle out_result=0x8000, flags V=1 C=0 N=1 Z=0, out_tag=3; op_count=1 after the handshake.
- SUB boundaries:
  - a=0x0005, b=0x0005 → result 0x0000, Z=1 C=1 N=0 V=0.
  - a=0x0000, b=0x0001 → 0xFFFF, C=0 N=1.
- Backpressure: out_ready=0, issue 4 back-to-back ADDs (tags 0..3).
  - Exactly 3 accepted (1 output + 2 buffered); in_ready low from the cycle after the third accept.
  - Raise out_ready: results emerge in tag order 0,1,2, then 3 is accepted, with no drops or duplicates.
- Streaming: 100 random ops with in_valid and out_ready held high → one result per cycle after 1-cycle latency. Each result and flag set matches a reference model; AND/OR always C=0 V=0.
- Reset mid-operation: assert rst asynchronously with FULL occupancy → out_valid=0, op_count=0, and in_ready=0 immediately. After release, in_ready=1 at the first edge and no stale result appears.
- Counter wrap: preload via 65535 accepted results, one more → op_count=0x0000.
